// File: rtl/sprite_ram_loader_pkg.sv
// Shared types and sizes for the sprite RAM loader: sprite ids, loader phases
// and the sprite geometry.
package sprite_pkg;

  typedef enum logic [2:0] {
    SPR_RED    = 3'd0,
    SPR_BLUE   = 3'd1,
    SPR_GREEN  = 3'd2,
    SPR_YELLOW = 3'd3,
    SPR_ORANGE = 3'd4
  } sprite_id_t;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_R   = 2'd1,
    S_G   = 2'd2,
    S_B   = 2'd3
  } loader_state_t;

  localparam int SPRITE_W          = 64;
  localparam int SPRITE_H          = 64;
  localparam int SPRITE_PIXELS_DEF = SPRITE_W * SPRITE_H;

endpackage

// File: rtl/sprite_ram_loader_if.sv
// Host byte stream into the sprite loader.
interface sprite_ram_loader_if;
  // A byte transfers on the rising clock edge where in_valid && in_ready;
  // in_data/in_valid must be stable around that edge. abort discards the
  // frame in progress and takes priority over a byte offered in the same cycle.
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;

  modport master (output in_data, output in_valid, output abort, input in_ready);
  modport slave  (input in_data, input in_valid, input abort, output in_ready);
endinterface

// File: rtl/sprite_ram_loader_packer.sv
// Collects R and G bytes and emits a registered {R,G,B} pixel with a
// one-cycle valid the cycle after the B byte is accepted.
module rgb_byte_packer
  import sprite_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  loader_state_t i_state,
  input  logic [7:0]    i_byte,
  input  logic          i_accept,
  output logic [23:0]   o_pixel,
  output logic          o_pixel_valid
);

  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [23:0] r_pixel;
  logic        r_pixel_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_red         <= '0;
      r_green       <= '0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      if (i_accept) begin
        case (i_state)
          S_R: r_red   <= i_byte;
          S_G: r_green <= i_byte;
          S_B: begin
            r_pixel       <= {r_red, r_green, i_byte};
            r_pixel_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_pixel       = r_pixel;
  assign o_pixel_valid = r_pixel_valid;

endmodule

// File: rtl/sprite_ram_loader.sv
// Streams a header byte plus R,G,B pixel bytes from the host into one of the
// per-colour sprite frame RAMs, one pixel per write, addresses 0..SPRITE_PIXELS-1.
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int SPRITE_PIXELS = SPRITE_PIXELS_DEF,
  parameter int ADDR_W        = 13,
  parameter int NUM_SPRITES   = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  sprite_ram_loader_if.slave     s_in,
  output logic [ADDR_W-1:0]      write_address,
  output logic [23:0]            write_data,
  output logic [NUM_SPRITES-1:0] we,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output loader_state_t          o_state
);

  localparam int ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  loader_state_t     r_state;
  loader_state_t     w_next_state;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_count;
  logic              r_last;
  logic              r_error;
  logic              w_accept;
  logic              w_hdr_ok;
  logic              w_hdr_take;
  logic              w_last_pixel;
  logic [23:0]       w_pixel;
  logic              w_pix_valid;

  // abort wins over a simultaneous byte, so it never counts as accepted.
  assign w_accept     = s_in.in_valid & s_in.in_ready & ~s_in.abort;
  assign w_hdr_ok     = (s_in.in_data < 8'(NUM_SPRITES));
  assign w_hdr_take   = w_accept && (r_state == S_HDR) && w_hdr_ok;
  assign w_last_pixel = (r_count == ADDR_W'(SPRITE_PIXELS - 1));

  always_comb begin
    w_next_state = r_state;
    if (s_in.abort) begin
      w_next_state = S_HDR;
    end else if (w_accept) begin
      case (r_state)
        S_HDR:   w_next_state = w_hdr_ok ? S_R : S_HDR;
        S_R:     w_next_state = S_G;
        S_G:     w_next_state = S_B;
        S_B:     w_next_state = w_last_pixel ? S_HDR : S_R;
        default: w_next_state = S_HDR;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_HDR;
      r_id    <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_error <= w_accept && (r_state == S_HDR) && !w_hdr_ok;
      // r_count is the index of the pixel being written until its write cycle ends.
      if (w_hdr_take) begin
        r_id    <= s_in.in_data[ID_W-1:0];
        r_count <= '0;
      end else if (w_pix_valid) begin
        r_count <= r_last ? '0 : r_count + ADDR_W'(1);
      end
      if (w_accept && (r_state == S_B)) begin
        r_last <= w_last_pixel;
      end
    end
  end

  rgb_byte_packer u_packer (
    .clk           (Clk),
    .rst_n         (Reset),
    .i_state       (r_state),
    .i_byte        (s_in.in_data),
    .i_accept      (w_accept),
    .o_pixel       (w_pixel),
    .o_pixel_valid (w_pix_valid)
  );

  assign s_in.in_ready = Reset;
  assign write_address = r_count;
  assign write_data    = w_pixel;
  assign we            = w_pix_valid ? (NUM_SPRITES'(1) << r_id) : '0;
  assign busy          = (r_state != S_HDR);
  assign done          = w_pix_valid & r_last;
  assign error         = r_error;
  assign o_state       = r_state;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: full frames, invalid header, gapped
// stream, abort and mid-frame reset.
module tb_sprite_ram_loader;
  import sprite_pkg::*;

  logic          Clk;
  logic          Reset;
  logic [12:0]   write_address;
  logic [23:0]   write_data;
  logic [4:0]    we;
  logic          busy;
  logic          done;
  logic          error;
  loader_state_t o_state;

  int n_cmp = 0;
  int n_err = 0;

  sprite_ram_loader_if bus ();

  sprite_ram_loader #(
    .SPRITE_PIXELS (4096),
    .ADDR_W        (13),
    .NUM_SPRITES   (5)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .s_in          (bus.slave),
    .write_address (write_address),
    .write_data    (write_data),
    .we            (we),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .o_state       (o_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_we", 32'(we), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  task automatic gaps(input bit rnd);
    if (rnd) begin
      while ($urandom_range(1, 0) == 0) idle_check(1);
    end
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int addr, input logic [4:0] we_exp,
                            input bit done_exp, input bit rnd);
    gaps(rnd);
    send_byte(r);
    chk("we_after_r", 32'(we), 32'd0);
    gaps(rnd);
    send_byte(g);
    chk("we_after_g", 32'(we), 32'd0);
    gaps(rnd);
    send_byte(b);
    chk("we_pulse", 32'(we), 32'(we_exp));
    chk("wr_addr", 32'(write_address), 32'(addr));
    chk("wr_data", 32'(write_data), {8'h00, r, g, b});
    chk("done_flag", 32'(done), 32'(done_exp));
  endtask

  task automatic pattern_frame(input logic [7:0] id, input logic [4:0] we_exp,
                               input int npix, input bit rnd);
    logic [7:0] kb;
    send_byte(id);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_state", 32'(o_state), 32'(S_R));
    for (int k = 0; k < npix; k++) begin
      kb = k[7:0];
      send_pixel(kb, 8'h5A, ~kb, k, we_exp, (k == 4095), rnd);
    end
  endtask

  initial begin
    Reset        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(write_address), 32'd0);
    chk("rst_data", 32'(write_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    Reset = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_state", 32'(o_state), 32'(S_HDR));

    // Full continuous frame into green sprite
    pattern_frame(8'h02, 5'b00100, 4096, 1'b0);
    chk("f2_end_state", 32'(o_state), 32'(S_HDR));
    chk("f2_end_busy", 32'(busy), 32'd0);
    idle_check(2);

    // Invalid header, then one pixel into orange sprite
    send_byte(8'h07);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_we", 32'(we), 32'd0);
    chk("bad_state", 32'(o_state), 32'(S_HDR));
    tick();
    chk("bad_error_clr", 32'(error), 32'd0);
    send_byte(8'h04);
    chk("hdr4_error", 32'(error), 32'd0);
    chk("hdr4_state", 32'(o_state), 32'(S_R));
    send_pixel(8'hFF, 8'h80, 8'h00, 0, 5'b10000, 1'b0, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort4_state", 32'(o_state), 32'(S_HDR));

    // Gapped frame into blue sprite
    pattern_frame(8'h01, 5'b00010, 4096, 1'b1);
    chk("f1_end_state", 32'(o_state), 32'(S_HDR));
    idle_check(2);

    // Abort after R,G of pixel 10; simultaneous byte is dropped
    pattern_frame(8'h00, 5'b00001, 10, 1'b0);
    send_byte(8'h0A);
    chk("ab_we_r", 32'(we), 32'd0);
    send_byte(8'h5A);
    chk("ab_we_g", 32'(we), 32'd0);
    bus.in_data  = 8'h33;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    chk("ab_we", 32'(we), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_state", 32'(o_state), 32'(S_HDR));
    chk("ab_error", 32'(error), 32'd0);
    idle_check(2);
    send_byte(8'h01);
    send_pixel(8'h11, 8'h22, 8'h33, 0, 5'b00010, 1'b0, 1'b0);
    send_pixel(8'h44, 8'h55, 8'h66, 1, 5'b00010, 1'b0, 1'b0);

    // Mid-frame reset on yellow sprite
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    pattern_frame(8'h03, 5'b01000, 100, 1'b0);
    Reset = 1'b0;
    #1;
    chk("mr_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("mr_we", 32'(we), 32'd0);
    chk("mr_addr", 32'(write_address), 32'd0);
    chk("mr_data", 32'(write_data), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_state", 32'(o_state), 32'(S_HDR));
    Reset = 1'b1;
    tick();
    send_byte(8'h03);
    send_pixel(8'hAB, 8'hCD, 8'hEF, 0, 5'b01000, 1'b0, 1'b0);
    idle_check(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
